decimal_key_debouncer: RTL and testbench

//  Front end for the 10-key decimal keypad. Synchronises raw key lines, debounces the

---
 rtl/decimal_key_debouncer.sv | 152 +++++++++++++++
 tb/tb_decimal_key_debouncer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decimal_key_debouncer.sv
// Decimal keypad front end: 2-FF synchroniser plus whole-vector debouncer.
// Presents a stable 10-bit key vector to the priority encoder, together with
// single-cycle press/release strobes. Multi-key vectors are passed through as-is.
module decimal_key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_raw,
    output logic [9:0] d,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_release
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StHeld,
        StRelease
    } state_e;

    // Terminal count: key_s must sit unchanged this many cycles before committing.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [9:0]       sync1_q, sync1_d;
    logic [9:0]       sync2_q, sync2_d;
    logic [9:0]       snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       d_q, d_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    logic [9:0]       key_s;

    assign key_s = sync2_q;

    // Synchroniser next-state: raw lines shift through two flops.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    // Debounce FSM next-state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        valid_d   = valid_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (key_s != '0) begin
                    state_d = StArm;
                    snap_d  = key_s;
                    cnt_d   = '0;
                end
            end

            StArm: begin
                if (key_s == '0) begin
                    // Short glitch: drop back silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (key_s != snap_q) begin
                    // Bounce or extra key: restart the stability window.
                    snap_d = key_s;
                    cnt_d  = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StHeld;
                    d_d     = snap_q;
                    valid_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StHeld: begin
                if (key_s != d_q) begin
                    state_d = StRelease;
                    snap_d  = key_s;
                    cnt_d   = '0;
                end
            end

            StRelease: begin
                if (key_s == d_q) begin
                    // Contact bounced back to the held vector: keep it, no pulse.
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (key_s != snap_q) begin
                    snap_d = key_s;
                    cnt_d  = '0;
                end else if (cnt_q == CntLast) begin
                    // A changed vector always releases first; IDLE re-debounces it.
                    state_d   = StIdle;
                    d_d       = '0;
                    valid_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sync1_q   <= '0;
            sync2_q   <= '0;
            snap_q    <= '0;
            cnt_q     <= '0;
            d_q       <= '0;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            valid_q   <= valid_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign d           = d_q;
    assign key_valid   = valid_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Scoreboard bench for decimal_key_debouncer (DEBOUNCE_CYCLES = 16).
// Stimulus pushes expected press/release events with their due cycle; a negedge
// monitor pops and compares whenever the DUT pulses key_press or key_release.
module tb_decimal_key_debouncer;

    localparam int Lat     = 19;  // key_raw change -> committed output
    localparam int SwapLat = 36;  // release commit, then a full fresh debounce

    logic       clk;
    logic       rst;
    logic [9:0] key_raw;
    logic [9:0] d;
    logic       key_valid;
    logic       key_press;
    logic       key_release;

    typedef struct {
        bit         is_press;
        logic [9:0] dv;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_pass;
    int   n_total;

    decimal_key_debouncer #(
        .DEBOUNCE_CYCLES(16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .d          (d),
        .key_valid  (key_valid),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_press, input logic [9:0] dv, input int due);
        exp_t e;
        e.is_press = is_press;
        e.dv       = dv;
        e.cyc      = due;
        sb.push_back(e);
    endtask

    // Leaves the caller 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_d"}, int'(d), 0);
        check({tag, "_valid"}, int'(key_valid), 0);
        check({tag, "_press"}, int'(key_press), 0);
        check({tag, "_release"}, int'(key_release), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_press && key_release) begin
                check("press_release_overlap", 1, 0);
            end
            if (key_press || key_release) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", int'({key_press, key_release}), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind_press", int'(key_press), int'(e.is_press));
                    check("pulse_d", int'(d), int'(e.dv));
                    check("pulse_valid", int'(key_valid), int'(e.is_press));
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int budget;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        key_raw = '0;
        tick(3);
        check_idle_outputs("reset");
        tick(1);
        rst = 1'b0;
        tick(2);

        // Clean press of key 3.
        key_raw = 10'h008;
        push(1'b1, 10'h008, cyc + Lat);
        tick(40);
        @(negedge clk);
        check("clean_d", int'(d), 'h008);
        check("clean_valid", int'(key_valid), 1);

        // Bouncy release: contact returns to the held vector every 3 cycles.
        tick(1);
        key_raw = '0;     tick(3);
        key_raw = 10'h008; tick(3);
        key_raw = '0;     tick(3);
        key_raw = 10'h008; tick(3);
        key_raw = '0;
        push(1'b0, 10'h000, cyc + Lat);
        tick(30);
        @(negedge clk);
        check("rel_d", int'(d), 0);
        check("rel_valid", int'(key_valid), 0);

        // Bouncy press of key 5: four 5-cycle toggles, then stable.
        tick(1);
        for (int i = 0; i < 4; i++) begin
            key_raw = (i % 2 == 0) ? 10'h020 : 10'h000;
            tick(5);
        end
        key_raw = 10'h020;
        push(1'b1, 10'h020, cyc + Lat);
        tick(40);
        @(negedge clk);
        check("bouncy_d", int'(d), 'h020);
        tick(1);
        key_raw = '0;
        push(1'b0, 10'h000, cyc + Lat);
        tick(30);

        // Glitch shorter than the debounce window.
        key_raw = 10'h001;
        tick(10);
        key_raw = '0;
        tick(30);
        @(negedge clk);
        check("glitch_d", int'(d), 0);
        check("glitch_valid", int'(key_valid), 0);

        // Multi-key vector, then a direct swap to key 7.
        tick(1);
        key_raw = 10'h208;
        push(1'b1, 10'h208, cyc + Lat);
        tick(30);
        key_raw = 10'h080;
        push(1'b0, 10'h000, cyc + Lat);
        push(1'b1, 10'h080, cyc + SwapLat);
        tick(50);
        @(negedge clk);
        check("swap_d", int'(d), 'h080);
        tick(1);
        key_raw = '0;
        push(1'b0, 10'h000, cyc + Lat);
        tick(30);

        // Reset while arming: no pulse, clean outputs, fresh press debounces normally.
        key_raw = 10'h004;
        tick(10);
        rst     = 1'b1;
        key_raw = '0;
        tick(1);
        check_idle_outputs("rst_arm");
        tick(1);
        rst = 1'b0;
        tick(3);
        key_raw = 10'h004;
        push(1'b1, 10'h004, cyc + Lat);
        tick(30);
        @(negedge clk);
        check("fresh_d", int'(d), 'h004);

        // Reset while held: outputs clear with no release strobe.
        tick(1);
        rst     = 1'b1;
        key_raw = '0;
        tick(1);
        check_idle_outputs("rst_held");
        tick(1);
        rst = 1'b0;
        tick(5);
        key_raw = 10'h040;
        push(1'b1, 10'h040, cyc + Lat);
        tick(30);
        key_raw = '0;
        push(1'b0, 10'h000, cyc + Lat);

        // Drain the scoreboard within a bounded number of cycles.
        budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(5);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
